// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution result output path.
package conv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_OUT  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } st_t;

    // One frame of results, index 0 is streamed first.
    typedef logic [N_OUT-1:0][DATA_W-1:0] frame_t;

endpackage : conv_pkg

// File: rtl/rise_detect.sv
// Single-cycle pulse on the rising edge of a level flag.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev_q;

    // Remember the previous sample of the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in;
        end
    end

    assign pulse = in & ~prev_q;

endmodule : rise_detect

// File: rtl/conv_result_streamer.sv
// Captures the four filter results on done_in rising and streams them
// over valid/ready with m_last on the final word.
// Optional build macro: CONV_OUT_RELU_EN (clamp negative results to 0 at capture).
module conv_result_streamer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = conv_pkg::DATA_W,
    parameter int unsigned N_OUT  = conv_pkg::N_OUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned     IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    typedef logic [N_OUT-1:0][DATA_W-1:0] words_t;

    st_t               state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    words_t            frame_q, frame_d;
    words_t            cap_c;
    logic              overrun_q, overrun_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              start_c;

    rise_detect u_rise (
        .clk   (clk),
        .rst   (rst),
        .in    (done_in),
        .pulse (start_c)
    );

    // Arrange the results in stream order, optionally clamping negatives.
    always_comb begin
        cap_c    = '0;
        cap_c[0] = c11;
        cap_c[1] = c12;
        cap_c[2] = c21;
        cap_c[3] = c22;
`ifdef CONV_OUT_RELU_EN
        for (int i = 0; i < int'(N_OUT); i++) begin
            if (cap_c[i][DATA_W-1]) begin
                cap_c[i] = '0;
            end
        end
`else
`endif
    end

    // Next-state logic; output registers are loaded from the next state so
    // nothing downstream sees a path from m_ready.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    frame_d = cap_c;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_ready && (idx_q == LAST_IDX)) begin
                    cnt_d = cnt_q + 8'd1;
                    if (start_c) begin
                        frame_d = cap_c;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (m_ready) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    // A frame arriving mid-stream is dropped.
                    if (start_c) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_SEND);
        data_d  = valid_d ? frame_d[idx_d] : data_q;
        last_d  = valid_d && (idx_d == LAST_IDX);
    end

    // State, buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    assign m_valid   = valid_q;
    assign m_data    = data_q;
    assign m_last    = last_q;
    assign busy      = (state_q == ST_SEND);
    assign overrun   = overrun_q;
    assign frame_cnt = cnt_q;

endmodule : conv_result_streamer
